// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx_param #(
   parameter int unsigned CLK_DIV    = 5208,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk_50,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_uart,
   output logic                 tx_busy
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam int unsigned BW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Elaboration-time guard on the legal parameter ranges.
   if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_tx_param: illegal parameter value");
   end

   state_t                r_state;
   logic [CW-1:0]         r_baud;
   logic [BW-1:0]         r_bit;
   logic                  r_stop;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_uart;
   logic                  r_ready;
   logic                  r_busy;
`ifdef UART_TX_PARITY_EN
   logic                  r_parity;
`endif

   logic                  w_bit_tick;

   assign w_bit_tick = (r_baud == CW'(CLK_DIV - 1));

   assign tx_uart  = r_uart;
   assign tx_ready = r_ready;
   assign tx_busy  = r_busy;

   // Frame sequencer; every output is updated in the same edge as the state.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_stop   <= 1'b0;
         r_shift  <= '0;
         r_uart   <= 1'b1;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         if (w_bit_tick) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + CW'(1);
         end

         case (r_state)
            S_IDLE: begin
               r_baud  <= '0;
               r_uart  <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
               if (tx_valid && r_ready) begin
                  r_state  <= S_START;
                  r_shift  <= tx_data;
                  r_bit    <= '0;
                  r_stop   <= 1'b0;
                  r_uart   <= 1'b0;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  r_parity <= (^tx_data) ^ 1'(PARITY_ODD);
`endif
               end
            end

            S_START: begin
               if (w_bit_tick) begin
                  r_state <= S_DATA;
                  r_bit   <= '0;
                  r_uart  <= r_shift[0];
               end
            end

            S_DATA: begin
               if (w_bit_tick) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_uart  <= r_parity;
`else
                     r_state <= S_STOP;
                     r_stop  <= 1'b0;
                     r_uart  <= 1'b1;
`endif
                  end else begin
                     r_bit  <= r_bit + BW'(1);
                     r_uart <= r_shift[1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_tick) begin
                  r_state <= S_STOP;
                  r_stop  <= 1'b0;
                  r_uart  <= 1'b1;
               end
            end
`endif

            S_STOP: begin
               r_uart <= 1'b1;
               if (w_bit_tick) begin
                  if (r_stop == 1'(STOP_BITS - 1)) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_stop <= r_stop + 1'b1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_baud  <= '0;
               r_uart  <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: several parameterisations share one clock/reset; expected
// line levels are queued when a word is driven and popped as each bit is sampled.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
   localparam int NI = 5;
   localparam int P  = 1;
`else
   localparam int NI = 3;
   localparam int P  = 0;
`endif
   localparam int CD = 4;

   logic       clk_50 = 1'b0;
   logic       rst_n;
   logic [8:0] data  [NI];
   logic       valid [NI];
   logic       uart  [NI];
   logic       ready [NI];
   logic       busy  [NI];

   int         checks   = 0;
   int         failures = 0;
   logic       exp_q [$];
   int         len_q [$];

   always #5 clk_50 = ~clk_50;

   uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_d0 (
      .clk_50(clk_50), .rst_n(rst_n), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx_uart(uart[0]), .tx_busy(busy[0]));

   uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_d1 (
      .clk_50(clk_50), .rst_n(rst_n), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx_uart(uart[1]), .tx_busy(busy[1]));

   uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u_d2 (
      .clk_50(clk_50), .rst_n(rst_n), .tx_data(data[2][4:0]), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx_uart(uart[2]), .tx_busy(busy[2]));

`ifdef UART_TX_PARITY_EN
   uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_d3 (
      .clk_50(clk_50), .rst_n(rst_n), .tx_data(data[3][7:0]), .tx_valid(valid[3]),
      .tx_ready(ready[3]), .tx_uart(uart[3]), .tx_busy(busy[3]));

   uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_d4 (
      .clk_50(clk_50), .rst_n(rst_n), .tx_data(data[4][7:0]), .tx_valid(valid[4]),
      .tx_ready(ready[4]), .tx_uart(uart[4]), .tx_busy(busy[4]));
`endif

   function automatic int dbits(input int k);
      return (k == 2) ? 5 : 8;
   endfunction

   function automatic int sbits(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic logic odd_of(input int k);
      return (k == 4) ? 1'b1 : 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a word and queue the line levels its frame must produce.
   task automatic drive(input int k, input logic [8:0] word);
      int   n;
      logic par;
      n   = 1;
      par = 1'b0;
      data[k]  = word;
      valid[k] = 1'b1;
      exp_q.push_back(1'b0);
      for (int i = 0; i < dbits(k); i++) begin
         exp_q.push_back(word[i]);
         par = par ^ word[i];
         n++;
      end
      if (P == 1) begin
         exp_q.push_back(par ^ odd_of(k));
         n++;
      end
      for (int i = 0; i < sbits(k); i++) begin
         exp_q.push_back(1'b1);
         n++;
      end
      len_q.push_back(n);
   endtask

   // Returns #1 after the accepting edge.
   task automatic wait_accept(input int k, input bit hold);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk_50);
         if (ready[k] === 1'b1) begin
            @(posedge clk_50);
            #1;
            ok = 1'b1;
         end
      end
      chk($sformatf("accept_dut%0d", k), 9'(ok), 9'd1);
      if (!hold) valid[k] = 1'b0;
   endtask

   task automatic check_frame(input int k, input string tag);
      int   n;
      logic b;
      if (len_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 9'd0, 9'd1);
      end else begin
         n = len_q.pop_front();
         for (int i = 0; i < n; i++) begin
            b = exp_q.pop_front();
            for (int c = 0; c < CD; c++) begin
               @(negedge clk_50);
               chk($sformatf("%s_bit%0d_c%0d_uart", tag, i, c), 9'(uart[k]), 9'(b));
               chk($sformatf("%s_bit%0d_c%0d_ready", tag, i, c), 9'(ready[k]), 9'd0);
               chk($sformatf("%s_bit%0d_c%0d_busy", tag, i, c), 9'(busy[k]), 9'd1);
            end
         end
      end
   endtask

   task automatic check_idle(input int k, input string tag);
      @(negedge clk_50);
      chk({tag, "_uart"}, 9'(uart[k]), 9'd1);
      chk({tag, "_ready"}, 9'(ready[k]), 9'd1);
      chk({tag, "_busy"}, 9'(busy[k]), 9'd0);
      @(posedge clk_50);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         valid[k] = 1'b0;
         data[k]  = 9'd0;
      end

      // Reset values, during and after reset
      #12;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_in_uart%0d", k), 9'(uart[k]), 9'd1);
         chk($sformatf("rst_in_ready%0d", k), 9'(ready[k]), 9'd1);
         chk($sformatf("rst_in_busy%0d", k), 9'(busy[k]), 9'd0);
      end
      @(negedge clk_50);
      rst_n = 1'b1;
      @(posedge clk_50);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_out_uart%0d", k), 9'(uart[k]), 9'd1);
         chk($sformatf("rst_out_ready%0d", k), 9'(ready[k]), 9'd1);
         chk($sformatf("rst_out_busy%0d", k), 9'(busy[k]), 9'd0);
      end

      // Single frame 0xA5
      drive(0, 9'h0A5);
      wait_accept(0, 1'b0);
      check_frame(0, "a5");
      check_idle(0, "a5_idle");

`ifdef UART_TX_PARITY_EN
      // Even then odd parity on 0xA5
      drive(3, 9'h0A5);
      wait_accept(3, 1'b0);
      check_frame(3, "par_even");
      check_idle(3, "par_even_idle");
      drive(4, 9'h0A5);
      wait_accept(4, 1'b0);
      check_frame(4, "par_odd");
      check_idle(4, "par_odd_idle");
`endif

      // Back-to-back with two stop bits; data changes while busy must be ignored
      drive(1, 9'h000);
      wait_accept(1, 1'b1);
      drive(1, 9'h0FF);
      check_frame(1, "b2b0");
      check_idle(1, "b2b_gap");
      valid[1] = 1'b0;
      data[1]  = 9'h055;
      check_frame(1, "b2b1");
      check_idle(1, "b2b_end");

      // Reset during DATA bit 3 of 0xC3 (bit 3 is 0)
      data[0]  = 9'h0C3;
      valid[0] = 1'b1;
      wait_accept(0, 1'b0);
      repeat (17) @(posedge clk_50);
      #2;
      chk("mid_pre_uart", 9'(uart[0]), 9'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_uart", 9'(uart[0]), 9'd1);
      chk("mid_rst_ready", 9'(ready[0]), 9'd1);
      chk("mid_rst_busy", 9'(busy[0]), 9'd0);
      @(negedge clk_50);
      rst_n = 1'b1;
      @(posedge clk_50);
      #1;
      drive(0, 9'h03C);
      wait_accept(0, 1'b0);
      check_frame(0, "post_rst_3c");
      check_idle(0, "post_rst_idle");

      // Five data bits
      drive(2, 9'h01F);
      wait_accept(2, 1'b0);
      check_frame(2, "db5");
      check_idle(2, "db5_idle");
      check_idle(2, "db5_idle2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
